// File: rtl/demux16_buf_if.sv
// Bus bundle for demux16_buf: one upstream word channel fanning out to 16 downstream channels.
// master = upstream source and downstream sinks; slave = the demux itself.
interface demux16_buf_if #(
  parameter int DW = 32
);
  logic [DW-1:0]        in_data;
  logic [3:0]           in_sel;
  logic                 in_valid;
  logic                 in_ready;
  logic [15:0][DW-1:0]  out_data;
  logic [15:0]          out_valid;
  logic [15:0]          out_ready;

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/demux16_buf.sv
// 1-to-16 demultiplexer with a single-entry holding register per channel.
// Optional feature: define DEMUX16_BUF_CNT_EN to add the 16-bit xfer_cnt accepted-word counter.
module demux16_buf #(
  parameter int DW = 32
) (
  input  logic               clk,
  input  logic               rst,
  demux16_buf_if.slave       bus
`ifdef DEMUX16_BUF_CNT_EN
  ,
  output logic [15:0]        xfer_cnt
`endif
);

  logic [15:0][DW-1:0] data_q, data_d;
  logic [15:0]         full_q, full_d;
  logic                in_ready_w;
  logic                accept_w;

  // Only the selected channel gates the input; a full channel that is being
  // drained this cycle can still take a new word.
  assign in_ready_w = ~full_q[bus.in_sel] | bus.out_ready[bus.in_sel];
  assign accept_w   = bus.in_valid & in_ready_w;

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_ch
      logic wr_w;
      assign wr_w        = accept_w && (bus.in_sel == 4'(gi));
      assign full_d[gi]  = wr_w | (full_q[gi] & ~bus.out_ready[gi]);
      assign data_d[gi]  = wr_w ? bus.in_data : data_q[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_data  = data_q;
  assign bus.out_valid = full_q;

`ifdef DEMUX16_BUF_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  assign cnt_d = accept_w ? cnt_q + 16'd1 : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_demux16_buf.sv
// Directed table plus hand-written corner sequences and a scoreboarded random run for demux16_buf.
module tb_demux16_buf;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  demux16_buf_if #(.DW(DW)) bus ();
`ifdef DEMUX16_BUF_CNT_EN
  logic [15:0] xfer_cnt;
`endif

  demux16_buf #(.DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus)
`ifdef DEMUX16_BUF_CNT_EN
    ,
    .xfer_cnt (xfer_cnt)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [3:0] s,
                       input logic [DW-1:0] d, input logic [15:0] ordy);
    rst           = r;
    bus.in_valid  = v;
    bus.in_sel    = s;
    bus.in_data   = d;
    bus.out_ready = ordy;
  endtask

  // One cycle: inputs set after the falling edge, in_ready sampled before the rising edge.
  task automatic cycle(input logic r, input logic v, input logic [3:0] s,
                       input logic [DW-1:0] d, input logic [15:0] ordy, output logic rdy);
    @(negedge clk);
    drive(r, v, s, d, ordy);
    #1 rdy = bus.in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    logic [DW-1:0] acc;
    acc = '0;
    for (int k = 0; k < 16; k++) acc = acc | bus.out_data[k];
    check(name, {32'h0, acc}, 64'h0);
  endtask

  typedef struct {
    logic          v;
    logic [3:0]    sel;
    logic [DW-1:0] data;
    logic [15:0]   ordy;
    logic          exp_rdy;
    logic [15:0]   exp_ov;
    logic [3:0]    ch;
    logic [DW-1:0] exp_d;
  } vec_t;

  vec_t vecs[10];
  logic rdy;
  logic [DW-1:0] held;
  logic [DW-1:0] q[16][$];

  initial begin
    vecs[0] = '{1'b1, 4'd3,  32'hA5A5_0003, 16'h0000, 1'b1, 16'h0008, 4'd3,  32'hA5A5_0003};
    vecs[1] = '{1'b0, 4'd3,  32'hDEAD_BEEF, 16'h0000, 1'b0, 16'h0008, 4'd3,  32'hA5A5_0003};
    vecs[2] = '{1'b1, 4'd5,  32'h5555_0005, 16'h0000, 1'b1, 16'h0028, 4'd5,  32'h5555_0005};
    vecs[3] = '{1'b1, 4'd5,  32'hBAD0_0005, 16'h0000, 1'b0, 16'h0028, 4'd5,  32'h5555_0005};
    vecs[4] = '{1'b1, 4'd2,  32'h1111_1111, 16'h0000, 1'b1, 16'h002C, 4'd2,  32'h1111_1111};
    vecs[5] = '{1'b1, 4'd2,  32'h2222_2222, 16'h0004, 1'b1, 16'h002C, 4'd2,  32'h2222_2222};
    vecs[6] = '{1'b0, 4'd0,  32'h0,         16'h0008, 1'b1, 16'h0024, 4'd2,  32'h2222_2222};
    vecs[7] = '{1'b1, 4'd15, 32'h0000_F00F, 16'h0024, 1'b1, 16'h8000, 4'd15, 32'h0000_F00F};
    vecs[8] = '{1'b1, 4'd15, 32'h0000_F11F, 16'h8000, 1'b1, 16'h8000, 4'd15, 32'h0000_F11F};
    vecs[9] = '{1'b1, 4'd0,  32'h0000_0000, 16'hFFFF, 1'b1, 16'h0001, 4'd0,  32'h0000_0000};

    // Reset and reset-state checks
    drive(1'b1, 1'b0, 4'd0, '0, 16'h0);
    repeat (2) @(posedge clk);
    cycle(1'b0, 1'b0, 4'd0, '0, 16'h0, rdy);
    check("reset_out_valid", {48'h0, bus.out_valid}, 64'h0);
    check_all_zero("reset_out_data");
    for (int s = 0; s < 16; s++) begin
      bus.in_sel = 4'(s);
      #1 check($sformatf("reset_in_ready_sel%0d", s), {63'h0, bus.in_ready}, 64'h1);
    end

    // Directed table
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, vecs[i].v, vecs[i].sel, vecs[i].data, vecs[i].ordy, rdy);
      $display("[TB] vec %0d: v=%0b sel=%0d data=%h ordy=%h -> rdy=%0b ov=%h", i,
               vecs[i].v, vecs[i].sel, vecs[i].data, vecs[i].ordy, rdy, bus.out_valid);
      check($sformatf("vec%0d_in_ready", i), {63'h0, rdy}, {63'h0, vecs[i].exp_rdy});
      check($sformatf("vec%0d_out_valid", i), {48'h0, bus.out_valid}, {48'h0, vecs[i].exp_ov});
      check($sformatf("vec%0d_out_data", i), {32'h0, bus.out_data[vecs[i].ch]}, {32'h0, vecs[i].exp_d});
    end

    // Backpressure on channel 5 while channel 7 drains independently
    cycle(1'b1, 1'b0, 4'd0, '0, 16'h0, rdy);
    cycle(1'b0, 1'b1, 4'd5, 32'hC0DE_0005, 16'h0, rdy);
    cycle(1'b0, 1'b1, 4'd7, 32'hC0DE_0007, 16'h0, rdy);
    for (int c = 0; c < 10; c++) begin
      cycle(1'b0, 1'b1, 4'd5, 32'hFFFF_0000 + c, (c == 3) ? 16'h0080 : 16'h0000, rdy);
      check($sformatf("bp_in_ready_c%0d", c), {63'h0, rdy}, 64'h0);
      check($sformatf("bp_data5_c%0d", c), {32'h0, bus.out_data[5]}, {32'h0, 32'hC0DE_0005});
    end
    $display("[TB] backpressure: ch5 stalled 10 cycles, ov=%h", bus.out_valid);
    check("bp_ch7_drained", {48'h0, bus.out_valid}, 64'h0020);
    cycle(1'b0, 1'b1, 4'd6, 32'hC0DE_0006, 16'h0, rdy);
    check("bp_sel6_ready", {63'h0, rdy}, 64'h1);
    check("bp_sel6_valid", {48'h0, bus.out_valid}, 64'h0060);
    check("bp_sel6_data", {32'h0, bus.out_data[6]}, {32'h0, 32'hC0DE_0006});

    // Reset in the middle of operation with a word presented
    for (int k = 0; k < 16; k++) cycle(1'b0, 1'b1, 4'(k), 32'hAB00_0000 + k, 16'h0, rdy);
    check("midrst_all_full", {48'h0, bus.out_valid}, 64'hFFFF);
    cycle(1'b1, 1'b1, 4'd9, 32'h9999_9999, 16'h0, rdy);
    $display("[TB] mid-operation reset: ov=%h", bus.out_valid);
    check("midrst_out_valid", {48'h0, bus.out_valid}, 64'h0);
    check_all_zero("midrst_out_data");
    cycle(1'b0, 1'b0, 4'd9, 32'h9999_9999, 16'h0, rdy);
    check("midrst_no_capture", {48'h0, bus.out_valid}, 64'h0);
    check("midrst_ready_after", {63'h0, rdy}, 64'h1);

    // Random stress against a per-channel order-preserving scoreboard
    for (int c = 0; c < 10000; c++) begin
      logic          v, exp_rdy;
      logic [3:0]    s;
      logic [DW-1:0] d;
      logic [15:0]   o, exp_ov;
      v = 1'($urandom_range(0, 1));
      s = 4'($urandom_range(0, 15));
      d = $urandom;
      o = 16'($urandom);
      @(negedge clk);
      drive(1'b0, v, s, d, o);
      #1;
      exp_rdy = (q[s].size() == 0) || o[s];
      check("rand_in_ready", {63'h0, bus.in_ready}, {63'h0, exp_rdy});
      for (int k = 0; k < 16; k++) begin
        if (o[k] && q[k].size() != 0) begin
          held = q[k].pop_front();
          check($sformatf("rand_order_ch%0d", k), {32'h0, bus.out_data[k]}, {32'h0, held});
        end
      end
      if (v && exp_rdy) q[s].push_back(d);
      @(posedge clk);
      #1;
      exp_ov = '0;
      for (int k = 0; k < 16; k++) exp_ov[k] = (q[k].size() != 0);
      check("rand_out_valid", {48'h0, bus.out_valid}, {48'h0, exp_ov});
    end
    $display("[TB] random stress: 10000 cycles done");

`ifdef DEMUX16_BUF_CNT_EN
    cycle(1'b1, 1'b0, 4'd0, '0, 16'h0, rdy);
    check("cnt_reset", {48'h0, xfer_cnt}, 64'h0);
    for (int c = 0; c < 65537; c++) begin
      cycle(1'b0, 1'b1, 4'(c % 16), 32'(c), 16'hFFFF, rdy);
      if (c % 4099 == 0) begin
        check("cnt_data_order", {32'h0, bus.out_data[c % 16]}, {32'h0, 32'(c)});
      end
    end
    $display("[TB] counter: 65537 words accepted, xfer_cnt=%h", xfer_cnt);
    check("cnt_wrap", {48'h0, xfer_cnt}, 64'h0001);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/demux16_buf.md
DEMUX16_BUF -- requirements
Module: demux16_buf

Interface
REQ-001 SHALL have parameter DW, default 32, width in bits of every data word.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_data, input, DW, the word to distribute.
REQ-005 SHALL have port in_sel, input, 4, destination channel index (0 to 15) for in_data.
REQ-006 SHALL have port in_valid, input, 1, upstream word present.
REQ-007 SHALL have port in_ready, output, 1, block accepts the word this cycle.
REQ-008 SHALL have port out_data, output, 16 x DW (packed array [15:0][DW-1:0]), per-channel held word.
REQ-009 SHALL have port out_valid, output, 16, per-channel word present.
REQ-010 SHALL have port out_ready, input, 16, per-channel downstream consumes.

Function
REQ-011 SHALL hold exactly one single-entry register per channel: data[k] (DW bits) and full[k] (1 bit); out_data[k] = data[k] and out_valid[k] = full[k].
REQ-012 SHALL drive in_ready = ~full[in_sel] | out_ready[in_sel], combinationally from the currently selected channel only.
REQ-013 SHALL accept a word when in_valid & in_ready; on that edge data[in_sel] <= in_data and full[in_sel] <= 1.
REQ-014 SHALL give a latency of exactly 1 cycle: an accepted word appears on out_data[in_sel] with out_valid high in the next cycle.
REQ-015 SHALL consume channel k when out_valid[k] & out_ready[k]; on that edge full[k] <= 0 unless REQ-016 applies.
REQ-016 SHALL, when channel k is consumed and written in the same cycle, load the new word and keep full[k] = 1, with no bubble and no loss.
REQ-017 SHALL leave data[k] and full[k] unchanged for every channel that is neither written nor consumed.
REQ-018 SHALL keep out_data[k] stable while out_valid[k] = 1 and out_ready[k] = 0.
REQ-019 SHALL let the other 15 channels drain independently when a full channel stalls the input.
REQ-020 SHALL ignore in_data and in_sel when in_valid = 0. in_ready may toggle with in_sel regardless of in_valid.
REQ-021 SHALL never drop or duplicate a word. Words sent to the same channel SHALL leave in acceptance order.

Reset
REQ-022 SHALL on rst = 1 at a clock edge clear full[15:0] to 0, so out_valid = 16'h0000, and clear data[k] to 0, so out_data = all zeros.
REQ-023 SHALL give reset priority over a simultaneous accept or consume; a word presented in a reset cycle is discarded.
REQ-024 SHALL drive in_ready = 1 for any in_sel in the first cycle after reset.
REQ-025 SHALL, on reset mid-operation, discard all held words with no partial state kept.

Configuration
REQ-026 SHALL use macro DEMUX16_BUF_CNT_EN. When defined, add output xfer_cnt, 16 bits, reset 0, incremented by 1 on every accepted input word, wrapping from 16'hFFFF to 16'h0000.
REQ-027 SHALL, when DEMUX16_BUF_CNT_EN is undefined, omit the xfer_cnt port and counter, with all other behaviour identical.

Verification
REQ-028 SHALL cover basic routing: reset, then in_data=32'hA5A5_0003, in_sel=3, in_valid=1 for one cycle with all out_ready=0 -> next cycle out_valid=16'h0008 and out_data[3]=32'hA5A5_0003; other channels stay invalid.
REQ-029 SHALL cover backpressure: channel 5 full, out_ready[5]=0, in_sel=5, in_valid=1 -> in_ready=0 and data[5] unchanged for 10 cycles. Switching in_sel to 6 -> in_ready=1 and the word lands in channel 6.
REQ-030 SHALL cover simultaneous consume and write: channel 2 holds 32'h1111_1111, out_ready[2]=1, input 32'h2222_2222 to sel 2 -> in_ready=1; the next cycle shows out_valid[2]=1 and out_data[2]=32'h2222_2222.
REQ-031 SHALL cover reset mid-operation: all 16 channels full, rst=1 for one cycle with in_valid=1 -> out_valid=16'h0000 and out_data all zero; no word is captured.
REQ-032 SHALL cover the counter with DEMUX16_BUF_CNT_EN defined: 65537 accepted words with all out_ready=1 and in_sel cycling 0..15 -> xfer_cnt=16'h0001; each channel's output order matches a reference model.
REQ-033 SHALL cover random stress: 10,000 cycles of random in_valid, in_sel and out_ready -> the scoreboard shows no lost, duplicated or reordered words per channel.
